// File: rtl/cpu_mem_arbiter_if.sv
// Bus bundle between the CPU's fetch/load-store ports, the arbiter and the memory.
// The slave modport is the arbiter's view; master is the core/memory side.
interface cpu_mem_arbiter_if #(
   parameter int AW = 32,
   parameter int DW = 32
);
   logic            if_req;
   logic [AW-1:0]   if_addr;
   logic [DW-1:0]   if_rdata;
   logic            if_done;

   logic            dm_req;
   logic            dm_we;
   logic [DW/8-1:0] dm_be;
   logic [AW-1:0]   dm_addr;
   logic [DW-1:0]   dm_wdata;
   logic [DW-1:0]   dm_rdata;
   logic            dm_done;

   logic            mem_en;
   logic            mem_we;
   logic [DW/8-1:0] mem_be;
   logic [AW-1:0]   mem_addr;
   logic [DW-1:0]   mem_wdata;
   logic [DW-1:0]   mem_rdata;

   modport slave (
      input  if_req, if_addr,
      output if_rdata, if_done,
      input  dm_req, dm_we, dm_be, dm_addr, dm_wdata,
      output dm_rdata, dm_done,
      output mem_en, mem_we, mem_be, mem_addr, mem_wdata,
      input  mem_rdata
   );

   modport master (
      output if_req, if_addr,
      input  if_rdata, if_done,
      output dm_req, dm_we, dm_be, dm_addr, dm_wdata,
      input  dm_rdata, dm_done,
      input  mem_en, mem_we, mem_be, mem_addr, mem_wdata,
      output mem_rdata
   );
endinterface

// File: rtl/cpu_mem_arbiter.sv
// Round-robin arbiter sharing one single-port memory between instruction fetch
// and load/store, one access at a time with a fixed memory read latency.
module cpu_mem_arbiter #(
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int MEM_LAT = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   cpu_mem_arbiter_if.slave     bus,
   output logic                 busy
);
   localparam int CW = (MEM_LAT < 1) ? 1 : $clog2(MEM_LAT + 1);

   if (MEM_LAT < 1) begin : g_bad_lat
      $error("cpu_mem_arbiter: MEM_LAT must be >= 1");
   end

   typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;
   typedef enum logic {OWN_IF, OWN_DM} owner_t;

   state_t        state;
   owner_t        owner;
   owner_t        last_owner;
   logic          owner_we;
   logic [CW-1:0] cnt;
   logic          grant_dm;

   // On a tie the port that did not go last wins.
   always_comb begin
      grant_dm = bus.dm_req && (!bus.if_req || (last_owner == OWN_IF));
   end

   always_comb begin
      busy = (state != IDLE);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state         <= IDLE;
         owner         <= OWN_IF;
         last_owner    <= OWN_IF;
         owner_we      <= 1'b0;
         cnt           <= '0;
         bus.mem_en    <= 1'b0;
         bus.mem_we    <= 1'b0;
         bus.mem_be    <= '0;
         bus.mem_addr  <= '0;
         bus.mem_wdata <= '0;
         bus.if_rdata  <= '0;
         bus.dm_rdata  <= '0;
         bus.if_done   <= 1'b0;
         bus.dm_done   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.if_req || bus.dm_req) begin
                  state      <= ACCESS;
                  bus.mem_en <= 1'b1;
                  if (grant_dm) begin
                     owner         <= OWN_DM;
                     last_owner    <= OWN_DM;
                     owner_we      <= bus.dm_we;
                     bus.mem_we    <= bus.dm_we;
                     bus.mem_be    <= bus.dm_be;
                     bus.mem_addr  <= bus.dm_addr;
                     bus.mem_wdata <= bus.dm_wdata;
                  end else begin
                     owner         <= OWN_IF;
                     last_owner    <= OWN_IF;
                     owner_we      <= 1'b0;
                     bus.mem_we    <= 1'b0;
                     bus.mem_be    <= '1;
                     bus.mem_addr  <= bus.if_addr;
                     bus.mem_wdata <= '0;
                  end
               end
            end
            ACCESS: begin
               bus.mem_en <= 1'b0;
               bus.mem_we <= 1'b0;
               cnt        <= CW'(MEM_LAT);
               state      <= WAIT;
            end
            WAIT: begin
               // Count of 1 marks the cycle in which mem_rdata is valid.
               if (cnt == CW'(1)) begin
                  if (!owner_we) begin
                     if (owner == OWN_DM) bus.dm_rdata <= bus.mem_rdata;
                     else                 bus.if_rdata <= bus.mem_rdata;
                  end
                  bus.if_done <= (owner == OWN_IF);
                  bus.dm_done <= (owner == OWN_DM);
                  state       <= DONE;
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end
            DONE: begin
               bus.if_done <= 1'b0;
               bus.dm_done <= 1'b0;
               state       <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// Directed bench for cpu_mem_arbiter: one instance with MEM_LAT=1, one with MEM_LAT=3,
// each fed by a small fixed-latency read model that returns junk outside the valid cycle.
module tb_cpu_mem_arbiter;
   logic clk;
   logic rst;
   logic busy1;
   logic busy3;
   int   checks;
   int   errors;

   cpu_mem_arbiter_if #(.AW(32), .DW(32)) b1 ();
   cpu_mem_arbiter_if #(.AW(32), .DW(32)) b3 ();

   cpu_mem_arbiter #(.AW(32), .DW(32), .MEM_LAT(1)) dut1 (
      .clk(clk), .rst(rst), .bus(b1), .busy(busy1)
   );
   cpu_mem_arbiter #(.AW(32), .DW(32), .MEM_LAT(3)) dut3 (
      .clk(clk), .rst(rst), .bus(b3), .busy(busy3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] rd(input logic [31:0] a);
      case (a)
         32'h10:  rd = 32'h0013_0313;
         32'h40:  rd = 32'h1234_5678;
         32'h44:  rd = 32'hCAFE_F00D;
         default: rd = a ^ 32'hA5A5_0000;
      endcase
   endfunction

   // Read models: data valid exactly MEM_LAT cycles after the mem_en cycle.
   logic        v1;
   logic [31:0] d1;
   logic [2:0]  v3;
   logic [31:0] d3 [3];
   always @(posedge clk) begin
      if (!rst) begin
         v1 <= 1'b0;
         v3 <= '0;
      end else begin
         v1 <= b1.mem_en && !b1.mem_we;
         v3 <= {v3[1:0], b3.mem_en && !b3.mem_we};
      end
      d1    <= rd(b1.mem_addr);
      d3[0] <= rd(b3.mem_addr);
      d3[1] <= d3[0];
      d3[2] <= d3[1];
   end
   assign b1.mem_rdata = v1 ? d1 : 32'hBAD0_BAD0;
   assign b3.mem_rdata = v3[2] ? d3[2] : 32'hBAD0_BAD0;

   task automatic test_reset();
      rst = 1'b0;
      b1.if_req = 1'b1; b1.dm_req = 1'b1;
      b3.if_req = 1'b1; b3.dm_req = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         checks++;
         if ({b1.mem_en, b1.if_done, b1.dm_done, busy1} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ctl1 got en/ifd/dmd/busy=%b exp 0000",
                     {b1.mem_en, b1.if_done, b1.dm_done, busy1});
         end
         checks++;
         if ({b3.mem_en, b3.if_done, b3.dm_done, busy3} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ctl3 got en/ifd/dmd/busy=%b exp 0000",
                     {b3.mem_en, b3.if_done, b3.dm_done, busy3});
         end
         checks++;
         if (b1.if_rdata !== 32'h0 || b1.dm_rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_rdata got if=%h dm=%h exp 0", b1.if_rdata, b1.dm_rdata);
         end
      end
      rst = 1'b1;
      b1.if_req = 1'b0; b1.dm_req = 1'b0;
      b3.if_req = 1'b0; b3.dm_req = 1'b0;
      checks++;
      if (busy1 !== 1'b0 || busy3 !== 1'b0) begin
         errors++;
         $display("FAIL reset_release_idle got busy1=%b busy3=%b exp 0", busy1, busy3);
      end
      @(negedge clk);
   endtask

   task automatic test_if_read();
      b1.if_req = 1'b1; b1.if_addr = 32'h10;
      @(negedge clk);
      checks++;
      if ({b1.mem_en, b1.mem_we, b1.mem_be} !== 6'b10_1111 || b1.mem_addr !== 32'h10) begin
         errors++;
         $display("FAIL if_access got en=%b we=%b be=%b addr=%h exp 1 0 1111 10",
                  b1.mem_en, b1.mem_we, b1.mem_be, b1.mem_addr);
      end
      @(negedge clk);
      checks++;
      if ({b1.mem_en, b1.if_done, busy1} !== 3'b001) begin
         errors++;
         $display("FAIL if_wait got en/ifd/busy=%b exp 001", {b1.mem_en, b1.if_done, busy1});
      end
      @(negedge clk);
      checks++;
      if ({b1.if_done, b1.dm_done} !== 2'b10 || b1.if_rdata !== 32'h0013_0313) begin
         errors++;
         $display("FAIL if_done got ifd=%b dmd=%b rdata=%h exp 1 0 00130313",
                  b1.if_done, b1.dm_done, b1.if_rdata);
      end
      b1.if_req = 1'b0;
      @(negedge clk);
      checks++;
      if ({b1.if_done, busy1} !== 2'b00) begin
         errors++;
         $display("FAIL if_after got ifd=%b busy=%b exp 0 0", b1.if_done, busy1);
      end
   endtask

   task automatic test_dm_store();
      b1.dm_req = 1'b1; b1.dm_we = 1'b1; b1.dm_addr = 32'h20;
      b1.dm_wdata = 32'hDEAD_BEEF; b1.dm_be = 4'b0011;
      @(negedge clk);
      checks++;
      if ({b1.mem_en, b1.mem_we, b1.mem_be} !== 6'b11_0011 ||
          b1.mem_wdata !== 32'hDEAD_BEEF || b1.mem_addr !== 32'h20) begin
         errors++;
         $display("FAIL st_access got en=%b we=%b be=%b wd=%h addr=%h exp 1 1 0011 deadbeef 20",
                  b1.mem_en, b1.mem_we, b1.mem_be, b1.mem_wdata, b1.mem_addr);
      end
      @(negedge clk);
      checks++;
      if ({b1.mem_en, b1.mem_we, b1.dm_done} !== 3'b000) begin
         errors++;
         $display("FAIL st_wait got en/we/dmd=%b exp 000", {b1.mem_en, b1.mem_we, b1.dm_done});
      end
      @(negedge clk);
      checks++;
      if ({b1.dm_done, b1.if_done} !== 2'b10 || b1.dm_rdata !== 32'h0) begin
         errors++;
         $display("FAIL st_done got dmd=%b ifd=%b dm_rdata=%h exp 1 0 0",
                  b1.dm_done, b1.if_done, b1.dm_rdata);
      end
      b1.dm_req = 1'b0; b1.dm_we = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_contention();
      logic [2:0]  exp;
      logic [31:0] exp_addr;
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      b1.dm_req = 1'b1; b1.dm_we = 1'b0; b1.dm_addr = 32'h40; b1.dm_be = 4'b1111;
      b1.if_req = 1'b1; b1.if_addr = 32'h10;
      for (int c = 1; c <= 16; c++) begin
         @(negedge clk);
         exp = {(c % 4 == 1), (c == 3 || c == 11), (c == 7 || c == 15)};
         checks++;
         if ({b1.mem_en, b1.dm_done, b1.if_done} !== exp) begin
            errors++;
            $display("FAIL rr_cycle%0d got en/dmd/ifd=%b exp %b",
                     c, {b1.mem_en, b1.dm_done, b1.if_done}, exp);
         end
         if (c % 4 == 1) begin
            exp_addr = (c % 8 == 1) ? 32'h40 : 32'h10;
            checks++;
            if (b1.mem_addr !== exp_addr) begin
               errors++;
               $display("FAIL rr_grant%0d got addr=%h exp %h", c, b1.mem_addr, exp_addr);
            end
         end
      end
      checks++;
      if (b1.dm_rdata !== 32'h1234_5678 || b1.if_rdata !== 32'h0013_0313) begin
         errors++;
         $display("FAIL rr_rdata got dm=%h if=%h exp 12345678 00130313",
                  b1.dm_rdata, b1.if_rdata);
      end
      b1.dm_req = 1'b0; b1.if_req = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic test_latency();
      logic [1:0] exp;
      b3.dm_req = 1'b1; b3.dm_we = 1'b0; b3.dm_addr = 32'h40; b3.dm_be = 4'b1111;
      for (int c = 1; c <= 6; c++) begin
         @(negedge clk);
         exp = {(c == 1), (c == 5)};
         checks++;
         if ({b3.mem_en, b3.dm_done} !== exp) begin
            errors++;
            $display("FAIL lat_cycle%0d got en/dmd=%b exp %b", c, {b3.mem_en, b3.dm_done}, exp);
         end
         if (c == 5) begin
            checks++;
            if (b3.dm_rdata !== 32'h1234_5678 || b3.if_done !== 1'b0) begin
               errors++;
               $display("FAIL lat_rdata got dm_rdata=%h ifd=%b exp 12345678 0",
                        b3.dm_rdata, b3.if_done);
            end
            b3.dm_req = 1'b0;
         end
      end
      checks++;
      if (busy3 !== 1'b0) begin
         errors++;
         $display("FAIL lat_idle got busy=%b exp 0", busy3);
      end
   endtask

   task automatic test_reset_mid_wait();
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      b3.if_req = 1'b1; b3.if_addr = 32'h44;
      @(negedge clk);
      checks++;
      if (b3.mem_en !== 1'b1) begin
         errors++;
         $display("FAIL rmw_access got en=%b exp 1", b3.mem_en);
      end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      b3.if_req = 1'b0;
      checks++;
      if ({busy3, b3.mem_en} !== 2'b00) begin
         errors++;
         $display("FAIL rmw_idle got busy=%b en=%b exp 0 0", busy3, b3.mem_en);
      end
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         checks++;
         if ({b3.if_done, b3.dm_done, busy3} !== 3'b000 || b3.if_rdata !== 32'h0) begin
            errors++;
            $display("FAIL rmw_quiet%0d got ifd/dmd/busy=%b if_rdata=%h exp 000 0",
                     c, {b3.if_done, b3.dm_done, busy3}, b3.if_rdata);
         end
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst = 1'b0;
      b1.if_req = 1'b0; b1.if_addr = '0; b1.dm_req = 1'b0; b1.dm_we = 1'b0;
      b1.dm_be = '0; b1.dm_addr = '0; b1.dm_wdata = '0;
      b3.if_req = 1'b0; b3.if_addr = '0; b3.dm_req = 1'b0; b3.dm_we = 1'b0;
      b3.dm_be = '0; b3.dm_addr = '0; b3.dm_wdata = '0;
      test_reset();
      test_if_read();
      test_dm_store();
      test_contention();
      test_latency();
      test_reset_mid_wait();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
